// File: rtl/key_injector_if.sv
// key_injector_if: keystroke injection port of key_injector
//  inj_data  {shift, ext, code[7:0]} keystroke to queue
//  inj_wr    write strobe, one entry per cycle high
//  inj_full  queue full, writes while full are dropped
//  busy      queue non-empty or a keystroke in progress
interface key_injector_if;
  logic [9:0] inj_data;
  logic       inj_wr;
  logic       inj_full;
  logic       busy;
  modport master (output inj_data, inj_wr, input inj_full, busy);
  modport slave (input inj_data, inj_wr, output inj_full, busy);
endinterface

// File: rtl/key_injector.sv
// key_injector: merges live PS/2 events with timed, FIFO-queued synthetic keystrokes
//  clk, reset   system clock, synchronous active-high reset
//  ce_11m       11 MHz clock enable driving the tick divider
//  ps2_key_in   live events {toggle, pressed, ext, code[7:0]}
//  ps2_key_out  merged stream, same format
//  inj          keystroke queue port (key_injector_if.slave)
module key_injector #(
  parameter int DEPTH      = 16,
  parameter int DIV_BITS   = 13,
  parameter int HOLD_TICKS = 4,
  parameter int GAP_TICKS  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce_11m,
  input  logic [10:0]   ps2_key_in,
  output logic [10:0]   ps2_key_out,
  key_injector_if.slave inj
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, MOD_DN, KEY_DN, KEY_UP, MOD_UP, GAP, ABORT} state_t;
  state_t state, nxt, ent;
  logic [9:0] mem [DEPTH];
  logic [9:0] head, ev;
  logic [8:0] cur, src;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [DIV_BITS-1:0] div;
  logic [7:0] wcnt, hold_n;
  logic old_stb, key_held, mod_held, pend;
  logic tick, live, abort, pop, wr, adv, want, fire;
  assign head = mem[rd_ptr];
  assign tick = ce_11m && div == '0;
  assign live = old_stb != ps2_key_in[10];
  assign inj.busy = count != '0 || state != IDLE;
  assign inj.inj_full = count == (AW+1)'(DEPTH);
  assign abort = live && ps2_key_in[9] && inj.busy;
  assign pop = state == IDLE && count != '0 && !abort;
  assign wr = inj.inj_wr && (!inj.inj_full || pop) && !abort;
  // pend: the current state's entry event has not gone out yet; its wait only runs once sent
  assign adv = !pend && wcnt == '0 && tick;
  always_ff @(posedge clk) old_stb <= ps2_key_in[10];
  always_ff @(posedge clk) if (wr) mem[wr_ptr] <= inj.inj_data;
  always_ff @(posedge clk) state <= reset ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = pop ? ent : IDLE;
      MOD_DN:  nxt = adv ? KEY_DN : MOD_DN;
      KEY_DN:  nxt = adv ? KEY_UP : KEY_DN;
      KEY_UP:  nxt = adv ? (mod_held ? MOD_UP : GAP) : KEY_UP;
      MOD_UP:  nxt = adv ? GAP : MOD_UP;
      GAP:     nxt = IDLE;
      ABORT:   nxt = (key_held || mod_held) ? ABORT : IDLE;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = ABORT;
  end
  // A pop emits the first event of the keystroke in the same cycle, straight from the FIFO head
  always_comb begin
    ent = pop ? (head[9] ? MOD_DN : KEY_DN) : state;
    src = pop ? head[8:0] : cur;
    want = pop || (state == ABORT ? (key_held || mod_held) : pend);
    fire = want && !live;
    ev = ent == MOD_DN ? 10'h212 :
         ent == KEY_DN ? {1'b1, src} :
         (ent == KEY_UP || (ent == ABORT && key_held)) ? {1'b0, cur} : 10'h012;
    hold_n = (ent == MOD_UP || (ent == KEY_UP && !mod_held)) ? 8'(GAP_TICKS - 1) : 8'(HOLD_TICKS - 1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ps2_key_out <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      cur <= '0;
      div <= '0;
      wcnt <= '0;
      key_held <= 1'b0;
      mod_held <= 1'b0;
      pend <= 1'b0;
    end else begin
      if (ce_11m) div <= div + DIV_BITS'(1);
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= abort ? wr_ptr : pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= abort ? '0 : count + (AW+1)'(wr) - (AW+1)'(pop);
      if (pop) cur <= head[8:0];
      if (live) ps2_key_out <= {~ps2_key_out[10], ps2_key_in[9:0]};
      else if (fire) ps2_key_out <= {~ps2_key_out[10], ev};
      pend <= nxt != state ? (nxt inside {MOD_DN, KEY_DN, KEY_UP, MOD_UP}) && !fire : pend && !fire;
      if (fire) wcnt <= hold_n;
      else if (tick && wcnt != '0) wcnt <= wcnt - 8'd1;
      if (fire && (ent == MOD_DN || ent == MOD_UP || (ent == ABORT && !key_held))) mod_held <= ent == MOD_DN;
      if (fire && (ent == KEY_DN || ent == KEY_UP || ent == ABORT)) key_held <= ent == KEY_DN;
    end
  end
endmodule
